// File: rtl/twowire_dtm_pkg.sv
// Shared DTM definitions: command codes, payload lengths, CSR layout and IDCODE.
// Also holds the command decode and payload-length helpers used by the engine.
package twowire_dtm_pkg;

  localparam logic [31:0] CMD_DISCONNECT = 32'h0;
  localparam logic [31:0] CMD_R_IDCODE   = 32'h1;
  localparam logic [31:0] CMD_R_CSR      = 32'h2;
  localparam logic [31:0] CMD_W_CSR      = 32'h3;
  localparam logic [31:0] CMD_W_ADDR     = 32'h5;
  localparam logic [31:0] CMD_W_DATA     = 32'h6;
  localparam logic [31:0] CMD_R_DATA     = 32'h7;

  localparam int LEN_DISCONNECT = 8;
  localparam int LEN_WORD       = 32;
  localparam int LEN_OTHER      = 8;

  localparam int CSR_BUSY     = 0;
  localparam int CSR_BUS_ERR  = 1;
  localparam int CSR_BUSY_ERR = 2;
  localparam int CSR_AUTOINC  = 3;

  localparam logic [31:0] IDCODE = 32'h0000_0f01;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_COMMIT
  } dtm_state_e;

  typedef enum logic [2:0] {
    OP_DISCONNECT,
    OP_R_IDCODE,
    OP_R_CSR,
    OP_W_CSR,
    OP_W_ADDR,
    OP_W_DATA,
    OP_R_DATA,
    OP_OTHER
  } dtm_op_e;

  function automatic dtm_op_e decode_cmd(input logic [31:0] code);
    dtm_op_e op;
    case (code)
      CMD_DISCONNECT: op = OP_DISCONNECT;
      CMD_R_IDCODE:   op = OP_R_IDCODE;
      CMD_R_CSR:      op = OP_R_CSR;
      CMD_W_CSR:      op = OP_W_CSR;
      CMD_W_ADDR:     op = OP_W_ADDR;
      CMD_W_DATA:     op = OP_W_DATA;
      CMD_R_DATA:     op = OP_R_DATA;
      default:        op = OP_OTHER;
    endcase
    return op;
  endfunction

  // Counter load value: the bit counter runs from length-1 down to 0.
  function automatic logic [CNT_W-1:0] payload_last(input dtm_op_e op);
    int len;
    case (op)
      OP_DISCONNECT: len = LEN_DISCONNECT;
      OP_OTHER:      len = LEN_OTHER;
      default:       len = LEN_WORD;
    endcase
    return CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/twowire_dtm_bus_master.sv
// Bus-side handshake of the DTM: address register, request/ack, read data buffer,
// autoincrement and busy/bus error detection.
module twowire_dtm_bus_master
  import twowire_dtm_pkg::*;
(
  input  logic        dck,
  input  logic        drst,
  input  logic        addr_load,
  input  logic [31:0] addr_value,
  input  logic        wr_start,
  input  logic        rd_start,
  input  logic [31:0] wr_value,
  input  logic        autoinc,
  input  logic        suppress,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_write,
  output logic        bus_req,
  output logic [31:0] data_buf,
  output logic        busy,
  output logic        set_bus_err,
  output logic        set_busy_err
);

  logic [31:0] addr_q;
  logic        ack_seen;
  logic        start;
  logic        launch;

  // An ack arriving while idle (e.g. after a reset mid-transfer) is ignored.
  assign ack_seen     = bus_req && bus_ack;
  assign start        = wr_start || rd_start;
  assign launch       = start && !suppress && !(bus_req && !bus_ack);
  assign set_bus_err  = ack_seen && bus_err;
  assign set_busy_err = start && !suppress && bus_req && !bus_ack;
  assign busy         = bus_req;
  assign bus_addr     = addr_q;

  always_ff @(posedge dck) begin
    if (drst) begin
      addr_q    <= '0;
      bus_req   <= 1'b0;
      bus_write <= 1'b0;
      bus_wdata <= '0;
      data_buf  <= '0;
    end else begin
      if (ack_seen) begin
        bus_req <= 1'b0;
        if (!bus_write) begin
          data_buf <= bus_rdata;
        end
        if (autoinc) begin
          addr_q <= addr_q + 32'd4;
        end
      end
      if (addr_load) begin
        addr_q <= addr_value;
      end
      if (launch) begin
        bus_req   <= 1'b1;
        bus_write <= wr_start;
        if (wr_start) begin
          bus_wdata <= wr_value;
        end
      end
    end
  end

endmodule

// File: rtl/twowire_dtm_payload_engine.sv
// DTM payload engine: shifts command payloads in/out bit-serially and commits
// completed writes to the address, CSR and bus master.
//
//   state     | meaning
//   ST_IDLE   | no payload in progress
//   ST_ACTIVE | payload bits being exchanged, counter tracks remaining bits
//   ST_COMMIT | final bit taken; commit side effects land at the end of this cycle
module twowire_dtm_payload_engine
  import twowire_dtm_pkg::*;
#(
  parameter int W_CMD = 4
) (
  input  logic             dck,
  input  logic             drst,
  input  logic             connected,
  input  logic [W_CMD-1:0] cmd,
  input  logic             cmd_vld,
  output logic             cmd_payload_end,
  input  logic             parity_err,
  input  logic             wdata,
  input  logic             wdata_vld,
  output logic             rdata,
  input  logic             rdata_rdy,
  output logic             disconnect_req,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  output logic             bus_write,
  output logic             bus_req,
  input  logic             bus_ack,
  input  logic             bus_err,
  input  logic [31:0]      bus_rdata
);

  dtm_state_e       state_q;
  dtm_state_e       state_d;
  dtm_op_e          op_q;
  dtm_op_e          cmd_op;
  logic             wr_q;
  logic             cmd_wr;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      sr_q;
  logic [31:0]      rd_src;
  logic [31:0]      csr_rd;
  logic [31:0]      data_buf;
  logic             load;
  logic             step;
  logic             handshake;
  logic             abort;
  logic             commit;
  logic             autoinc_q;
  logic             bus_err_q;
  logic             busy_err_q;
  logic             busy;
  logic             set_bus_err;
  logic             set_busy_err;
  logic             addr_load;
  logic             wr_start;
  logic             rd_start;

  assign cmd_op    = decode_cmd(32'(cmd));
  // Even popcount marks a write command.
  assign cmd_wr    = ~^cmd;
  assign handshake = wr_q ? wdata_vld : rdata_rdy;
  assign abort     = parity_err || !connected;
  assign commit    = (state_q == ST_COMMIT);

  assign cmd_payload_end = (state_q == ST_ACTIVE) && (cnt_q == '0);
  assign rdata           = sr_q[0];

  always_ff @(posedge dck) begin
    if (drst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_vld) begin
          state_d = ST_ACTIVE;
          load    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cmd_vld) begin
          load = 1'b1;
        end else if (handshake) begin
          step = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        if (cmd_vld) begin
          state_d = ST_ACTIVE;
          load    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_rd               = '0;
    csr_rd[CSR_BUSY]     = busy;
    csr_rd[CSR_BUS_ERR]  = bus_err_q;
    csr_rd[CSR_BUSY_ERR] = busy_err_q;
    csr_rd[CSR_AUTOINC]  = autoinc_q;
  end

  always_comb begin
    rd_src = '0;
    case (cmd_op)
      OP_R_IDCODE: rd_src = IDCODE;
      OP_R_CSR:    rd_src = csr_rd;
      OP_R_DATA:   rd_src = data_buf;
      default:     rd_src = '0;
    endcase
  end

  // Writes and reads share one right-shifting register; reads zero-fill from the top.
  always_ff @(posedge dck) begin
    if (drst) begin
      op_q  <= OP_OTHER;
      wr_q  <= 1'b0;
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (load) begin
      op_q  <= cmd_op;
      wr_q  <= cmd_wr;
      cnt_q <= payload_last(cmd_op);
      sr_q  <= cmd_wr ? '0 : rd_src;
    end else if (step) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      sr_q <= {wr_q & wdata, sr_q[31:1]};
    end
  end

  // Error sets win over a same-cycle W1C clear so no event is lost.
  always_ff @(posedge dck) begin
    if (drst) begin
      autoinc_q      <= 1'b0;
      bus_err_q      <= 1'b0;
      busy_err_q     <= 1'b0;
      disconnect_req <= 1'b0;
    end else begin
      disconnect_req <= commit && (op_q == OP_DISCONNECT);
      if (commit && (op_q == OP_W_CSR)) begin
        autoinc_q <= sr_q[CSR_AUTOINC];
        if (sr_q[CSR_BUS_ERR]) begin
          bus_err_q <= 1'b0;
        end
        if (sr_q[CSR_BUSY_ERR]) begin
          busy_err_q <= 1'b0;
        end
      end
      if (set_bus_err) begin
        bus_err_q <= 1'b1;
      end
      if (set_busy_err) begin
        busy_err_q <= 1'b1;
      end
    end
  end

  assign addr_load = commit && (op_q == OP_W_ADDR);
  assign wr_start  = commit && (op_q == OP_W_DATA);
  assign rd_start  = commit && (op_q == OP_R_DATA);

  twowire_dtm_bus_master u_bus_master (
    .dck          (dck),
    .drst         (drst),
    .addr_load    (addr_load),
    .addr_value   (sr_q),
    .wr_start     (wr_start),
    .rd_start     (rd_start),
    .wr_value     (sr_q),
    .autoinc      (autoinc_q),
    .suppress     (bus_err_q || busy_err_q),
    .bus_ack      (bus_ack),
    .bus_err      (bus_err),
    .bus_rdata    (bus_rdata),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_write    (bus_write),
    .bus_req      (bus_req),
    .data_buf     (data_buf),
    .busy         (busy),
    .set_bus_err  (set_bus_err),
    .set_busy_err (set_busy_err)
  );

endmodule
